// File: rtl/controller.sv
// ---------------------------------------------------------------------------
// controller -- RV32I main instruction decoder with a one-cycle registered
// output stage.
//
// Decodes opcode/funct3/funct7 combinationally and registers every control
// output on the rising edge of clk. Any unlisted opcode, or an illegal
// funct3/funct7 combination, decodes to NOP (all outputs zero).
//
// Ports:
//   clk         in  1  sole clock, rising edge
//   rst         in  1  synchronous active-high reset (forces NOP)
//   opcode      in  7  instr[6:0]
//   f3          in  3  funct3
//   f7          in  7  funct7
//   regWR       out 1  register-file write enable
//   memRD       out 1  data-memory read
//   memWR       out 1  data-memory write
//   wbCtrl      out 2  writeback select: 00 ALU, 01 memory, 10 PC+4
//   aluOp       out 4  ALU operation
//   aluS1       out 1  ALU operand A: 0 rs1, 1 PC
//   aluS2       out 1  ALU operand B: 0 rs2, 1 immediate
//   branchCtrl  out 3  branch condition (funct3 of a branch)
//   memCtrl     out 3  access size/sign (funct3 of a load/store)
//   doBranch    out 1  conditional branch instruction
//   doJump      out 1  JAL/JALR instruction
// ---------------------------------------------------------------------------
module controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] f3,
   input  logic [6:0] f7,
   output logic       regWR,
   output logic       memRD,
   output logic       memWR,
   output logic [1:0] wbCtrl,
   output logic [3:0] aluOp,
   output logic       aluS1,
   output logic       aluS2,
   output logic [2:0] branchCtrl,
   output logic [2:0] memCtrl,
   output logic       doBranch,
   output logic       doJump
);

   typedef enum logic [6:0] {
      OP_RTYPE  = 7'b0110011,
      OP_IALU   = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111
   } opcode_e;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_PASSB = 4'b1111;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic       nRegWR;
   logic       nMemRD;
   logic       nMemWR;
   logic [1:0] nWbCtrl;
   logic [3:0] nAluOp;
   logic       nAluS1;
   logic       nAluS2;
   logic [2:0] nBranchCtrl;
   logic [2:0] nMemCtrl;
   logic       nDoBranch;
   logic       nDoJump;
   logic       iLegal;

   // Decode: everything defaults to NOP, each legal class sets only its own
   // fields, so illegal combinations fall through to all-zero.
   always_comb begin
      nRegWR      = 1'b0;
      nMemRD      = 1'b0;
      nMemWR      = 1'b0;
      nWbCtrl     = WB_ALU;
      nAluOp      = ALU_ADD;
      nAluS1      = 1'b0;
      nAluS2      = 1'b0;
      nBranchCtrl = '0;
      nMemCtrl    = '0;
      nDoBranch   = 1'b0;
      nDoJump     = 1'b0;
      iLegal      = 1'b0;

      case (opcode)
         OP_RTYPE: begin
            // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
            if ((f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
               nRegWR = 1'b1;
               nAluOp = {f7[5], f3};
            end
         end
         OP_IALU: begin
            // funct7 is part of the shift encoding only; otherwise it is
            // immediate bits and must be ignored.
            case (f3)
               3'b001:  iLegal = (f7 == F7_BASE);
               3'b101:  iLegal = (f7 == F7_BASE) || (f7 == F7_ALT);
               default: iLegal = 1'b1;
            endcase
            if (iLegal) begin
               nRegWR = 1'b1;
               nAluS2 = 1'b1;
               nAluOp = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
            end
         end
         OP_LOAD: begin
            if ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101)) begin
               nRegWR   = 1'b1;
               nMemRD   = 1'b1;
               nAluS2   = 1'b1;
               nWbCtrl  = WB_MEM;
               nMemCtrl = f3;
            end
         end
         OP_STORE: begin
            if ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010)) begin
               nMemWR   = 1'b1;
               nAluS2   = 1'b1;
               nMemCtrl = f3;
            end
         end
         OP_BRANCH: begin
            if ((f3 != 3'b010) && (f3 != 3'b011)) begin
               nDoBranch   = 1'b1;
               nBranchCtrl = f3;
               nAluS1      = 1'b1;
               nAluS2      = 1'b1;
            end
         end
         OP_LUI: begin
            nRegWR = 1'b1;
            nAluS2 = 1'b1;
            nAluOp = ALU_PASSB;
         end
         OP_AUIPC: begin
            nRegWR = 1'b1;
            nAluS1 = 1'b1;
            nAluS2 = 1'b1;
         end
         OP_JAL: begin
            nRegWR  = 1'b1;
            nDoJump = 1'b1;
            nAluS1  = 1'b1;
            nAluS2  = 1'b1;
            nWbCtrl = WB_PC4;
         end
         OP_JALR: begin
            if (f3 == 3'b000) begin
               nRegWR  = 1'b1;
               nDoJump = 1'b1;
               nAluS2  = 1'b1;
               nWbCtrl = WB_PC4;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regWR      <= 1'b0;
         memRD      <= 1'b0;
         memWR      <= 1'b0;
         wbCtrl     <= '0;
         aluOp      <= '0;
         aluS1      <= 1'b0;
         aluS2      <= 1'b0;
         branchCtrl <= '0;
         memCtrl    <= '0;
         doBranch   <= 1'b0;
         doJump     <= 1'b0;
      end else begin
         regWR      <= nRegWR;
         memRD      <= nMemRD;
         memWR      <= nMemWR;
         wbCtrl     <= nWbCtrl;
         aluOp      <= nAluOp;
         aluS1      <= nAluS1;
         aluS2      <= nAluS2;
         branchCtrl <= nBranchCtrl;
         memCtrl    <= nMemCtrl;
         doBranch   <= nDoBranch;
         doJump     <= nDoJump;
      end
   end

endmodule

// File: tb/tb_controller.sv
// ---------------------------------------------------------------------------
// tb_controller -- scoreboard bench for the controller decoder.
// Stimulus is driven on the falling edge and the expected registered result
// is queued; a monitor pops and compares shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_controller;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       regWR;
   logic       memRD;
   logic       memWR;
   logic [1:0] wbCtrl;
   logic [3:0] aluOp;
   logic       aluS1;
   logic       aluS2;
   logic [2:0] branchCtrl;
   logic [2:0] memCtrl;
   logic       doBranch;
   logic       doJump;

   typedef struct packed {
      logic       regWR;
      logic       memRD;
      logic       memWR;
      logic [1:0] wbCtrl;
      logic [3:0] aluOp;
      logic       aluS1;
      logic       aluS2;
      logic [2:0] branchCtrl;
      logic [2:0] memCtrl;
      logic       doBranch;
      logic       doJump;
   } ctrl_t;

   typedef struct {
      ctrl_t v;
      string name;
   } sbEntry_t;

   sbEntry_t sbQ[$];
   int vectors     = 0;
   int miscompares = 0;

   controller dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .f3         (f3),
      .f7         (f7),
      .regWR      (regWR),
      .memRD      (memRD),
      .memWR      (memWR),
      .wbCtrl     (wbCtrl),
      .aluOp      (aluOp),
      .aluS1      (aluS1),
      .aluS2      (aluS2),
      .branchCtrl (branchCtrl),
      .memCtrl    (memCtrl),
      .doBranch   (doBranch),
      .doJump     (doJump)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: instruction-class view of RV32I control signals.
   function automatic ctrl_t refModel(input logic [6:0] op, input logic [2:0] fn3,
                                      input logic [6:0] fn7, input logic r);
      ctrl_t e;
      int    f3i;
      e   = '0;
      f3i = int'(fn3);
      if (r) return e;
      case (op)
         7'b0110011: begin
            if (fn7 == 7'h00) begin
               e.regWR = 1; e.aluOp = 4'(f3i);
            end else if (fn7 == 7'h20 && f3i == 0) begin
               e.regWR = 1; e.aluOp = 4'd8;     // SUB
            end else if (fn7 == 7'h20 && f3i == 5) begin
               e.regWR = 1; e.aluOp = 4'd13;    // SRA
            end
         end
         7'b0010011: begin
            if (f3i == 1) begin
               if (fn7 == 7'h00) begin e.regWR = 1; e.aluS2 = 1; e.aluOp = 4'd1; end
            end else if (f3i == 5) begin
               if (fn7 == 7'h00) begin e.regWR = 1; e.aluS2 = 1; e.aluOp = 4'd5; end
               else if (fn7 == 7'h20) begin e.regWR = 1; e.aluS2 = 1; e.aluOp = 4'd13; end
            end else begin
               e.regWR = 1; e.aluS2 = 1; e.aluOp = 4'(f3i);
            end
         end
         7'b0000011: if (f3i inside {0, 1, 2, 4, 5}) begin
            e.regWR = 1; e.memRD = 1; e.aluS2 = 1; e.wbCtrl = 2'd1; e.memCtrl = fn3;
         end
         7'b0100011: if (f3i <= 2) begin
            e.memWR = 1; e.aluS2 = 1; e.memCtrl = fn3;
         end
         7'b1100011: if (f3i inside {0, 1, 4, 5, 6, 7}) begin
            e.doBranch = 1; e.branchCtrl = fn3; e.aluS1 = 1; e.aluS2 = 1;
         end
         7'b0110111: begin e.regWR = 1; e.aluS2 = 1; e.aluOp = 4'd15; end
         7'b0010111: begin e.regWR = 1; e.aluS1 = 1; e.aluS2 = 1; end
         7'b1101111: begin
            e.regWR = 1; e.doJump = 1; e.aluS1 = 1; e.aluS2 = 1; e.wbCtrl = 2'd2;
         end
         7'b1100111: if (f3i == 0) begin
            e.regWR = 1; e.doJump = 1; e.aluS2 = 1; e.wbCtrl = 2'd2;
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic apply(input logic [6:0] op, input logic [2:0] fn3,
                        input logic [6:0] fn7, input logic r, input string name);
      sbEntry_t s;
      @(negedge clk);
      opcode = op;
      f3     = fn3;
      f7     = fn7;
      rst    = r;
      s.v    = refModel(op, fn3, fn7, r);
      s.name = name;
      sbQ.push_back(s);
   endtask

   // Monitor: the registered outputs are valid every cycle after an edge.
   initial begin
      sbEntry_t s;
      ctrl_t    act;
      forever begin
         @(posedge clk);
         #1;
         if (sbQ.size() > 0) begin
            s   = sbQ.pop_front();
            act = {regWR, memRD, memWR, wbCtrl, aluOp, aluS1, aluS2,
                   branchCtrl, memCtrl, doBranch, doJump};
            vectors++;
            if (act !== s.v) begin
               miscompares++;
               $display("FAIL %s: got %b expected %b", s.name, act, s.v);
            end
            if ((doBranch && doJump) || (memRD && memWR)) begin
               miscompares++;
               $display("FAIL %s exclusive: got br=%b jmp=%b rd=%b wr=%b expected no overlap",
                        s.name, doBranch, doJump, memRD, memWR);
            end
         end
      end
   end

   logic [6:0] opList [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                              7'b1100111};

   initial begin
      logic [6:0] op;
      logic [6:0] fn7;
      int         waited;
      rst    = 1'b1;
      opcode = '0;
      f3     = '0;
      f7     = '0;

      // Reset state and reset overriding a legal decode
      apply(7'b0110011, 3'b000, 7'h00, 1'b1, "reset_rtype");
      apply(7'b1101111, 3'b000, 7'h00, 1'b1, "reset_jal");
      // Directed cases
      apply(7'b0110011, 3'b000, 7'h00, 1'b0, "r_add");
      apply(7'b0110011, 3'b000, 7'h20, 1'b0, "r_sub");
      apply(7'b0110011, 3'b001, 7'h20, 1'b0, "r_sll_badf7");
      apply(7'b0110011, 3'b101, 7'h20, 1'b0, "r_sra");
      apply(7'b0010011, 3'b101, 7'h20, 1'b0, "i_srai");
      apply(7'b0010011, 3'b001, 7'h20, 1'b0, "i_slli_badf7");
      apply(7'b0010011, 3'b110, 7'h7f, 1'b0, "i_ori_f7ignored");
      apply(7'b0000011, 3'b100, 7'h00, 1'b0, "ld_lbu");
      apply(7'b0000011, 3'b011, 7'h00, 1'b0, "ld_illegal");
      apply(7'b0100011, 3'b010, 7'h00, 1'b0, "st_sw");
      apply(7'b0100011, 3'b100, 7'h00, 1'b0, "st_illegal");
      apply(7'b1100011, 3'b101, 7'h00, 1'b0, "br_bge");
      apply(7'b1100011, 3'b010, 7'h00, 1'b0, "br_illegal");
      apply(7'b0110111, 3'b111, 7'h00, 1'b0, "lui");
      apply(7'b0010111, 3'b011, 7'h00, 1'b0, "auipc");
      apply(7'b1101111, 3'b000, 7'h00, 1'b0, "jal");
      apply(7'b1100111, 3'b000, 7'h00, 1'b0, "jalr");
      apply(7'b1100111, 3'b001, 7'h00, 1'b0, "jalr_illegal");
      apply(7'b0011111, 3'b000, 7'h00, 1'b0, "bad_opcode");
      // Reset held with a legal opcode, then release
      apply(7'b0000011, 3'b010, 7'h00, 1'b1, "reset_hold_lw");
      apply(7'b0000011, 3'b010, 7'h00, 1'b0, "release_lw");

      // Randomized: mostly legal opcodes, f7 biased to the meaningful values
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) op = 7'($urandom);
         else op = opList[$urandom_range(0, 8)];
         case ($urandom_range(0, 2))
            0:       fn7 = 7'h00;
            1:       fn7 = 7'h20;
            default: fn7 = 7'($urandom);
         endcase
         apply(op, 3'($urandom), fn7, ($urandom_range(0, 15) == 0), $sformatf("rand%0d", i));
      end

      // Drain the scoreboard with a bounded wait
      waited = 0;
      while (sbQ.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (sbQ.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending entries expected 0", sbQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock, rising edge); rst in 1 (synchronous, active-high reset).
REQ-002 SHALL have inputs: opcode in 7 (instr[6:0]); f3 in 3 (funct3); f7 in 7 (funct7).
REQ-003 SHALL have outputs: regWR out 1 (register-file write enable); memRD out 1 (data-memory read); memWR out 1 (data-memory write).
REQ-004 SHALL have outputs: wbCtrl out 2 (writeback select: 00 ALU, 01 memory, 10 PC+4; 11 never driven).
REQ-005 SHALL have outputs: aluOp out 4; aluS1 out 1 (0 rs1, 1 PC); aluS2 out 1 (0 rs2, 1 immediate).
REQ-006 SHALL have outputs: branchCtrl out 3 (branch condition = f3); memCtrl out 3 (access size/sign = f3); doBranch out 1; doJump out 1.

Function
REQ-007 SHALL decode combinationally from opcode/f3/f7 and register all outputs on the rising clk edge; latency exactly 1 cycle.
REQ-008 SHALL encode aluOp as: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101, PASSB 1111.
REQ-009 SHALL produce "NOP" as all outputs 0 for any unlisted opcode or illegal f3/f7 combination.
REQ-010 R-type 0110011: regWR=1, aluS1=0, aluS2=0, wbCtrl=00, aluOp={f7[5],f3}; legal only when f7=0000000, or f7=0100000 with f3 000/101; otherwise NOP.
REQ-011 I-ALU 0010011: regWR=1, aluS1=0, aluS2=1, wbCtrl=00; aluOp={0,f3} except f3=101 gives {f7[5],101}; f3=001 requires f7=0000000, f3=101 requires f7 0000000/0100000, else NOP; f7 ignored for other f3.
REQ-012 Load 0000011: regWR=1, memRD=1, aluS2=1, aluOp=ADD, wbCtrl=01, memCtrl=f3; legal f3 000,001,010,100,101; else NOP.
REQ-013 Store 0100011: memWR=1, aluS2=1, aluOp=ADD, memCtrl=f3, regWR=0; legal f3 000,001,010; else NOP.
REQ-014 Branch 1100011: doBranch=1, branchCtrl=f3, aluS1=1, aluS2=1, aluOp=ADD, regWR=0; legal f3 000,001,100,101,110,111; else NOP.
REQ-015 LUI 0110111: regWR=1, aluS2=1, aluOp=PASSB, wbCtrl=00; f3 ignored.
REQ-016 AUIPC 0010111: regWR=1, aluS1=1, aluS2=1, aluOp=ADD, wbCtrl=00; f3 ignored.
REQ-017 JAL 1101111: regWR=1, doJump=1, aluS1=1, aluS2=1, aluOp=ADD, wbCtrl=10; f3 ignored.
REQ-018 JALR 1100111: regWR=1, doJump=1, aluS1=0, aluS2=1, aluOp=ADD, wbCtrl=10; legal only f3=000, else NOP.
REQ-019 Any output not listed for a legal class SHALL be 0; memCtrl and branchCtrl SHALL be 000 outside load/store and branch respectively.
REQ-020 doBranch and doJump SHALL never both be 1; memRD and memWR SHALL never both be 1.

Reset
REQ-021 rst=1 at a rising edge SHALL force every registered output to 0 (NOP), overriding decode.
REQ-022 After rst deasserts, first edge SHALL register decode of current inputs; no other state exists.

Verification
REQ-023 opcode 0110011, f3 000, f7 0000000 -> next edge: regWR=1, aluOp=0000, aluS1=0, aluS2=0, wbCtrl=00; then f7 0100000 -> aluOp=1000.
REQ-024 opcode 0010011, f3 101, f7 0100000 -> aluOp=1101, aluS2=1; f3 001, f7 0100000 -> all 0.
REQ-025 opcode 0000011, f3 100 -> memRD=1, wbCtrl=01, memCtrl=100, regWR=1; f3 011 -> all 0.
REQ-026 opcode 1100011, f3 101 -> doBranch=1, branchCtrl=101, regWR=0; f3 010 -> all 0.
REQ-027 opcode 1101111 -> doJump=1, wbCtrl=10, aluS1=1; opcode 1100111 f3 000 -> doJump=1, aluS1=0; opcode 0011111 -> all 0.
REQ-028 Any legal opcode held with rst=1 across an edge -> all outputs 0; rst=0 -> decode appears after next edge.
